// File: rtl/dm_cache_pkg.sv
// Shared widths, FSM state type and address field helpers for the direct-mapped cache controller.
package dm_cache_pkg;
   localparam int ADDR_W   = 32;
   localparam int INDEX_W  = 10;
   localparam int TAG_W    = 18;
   localparam int LINE_W   = 128;
   localparam int WORD_W   = 32;
   localparam int OFFSET_W = 4;
   localparam int LINES    = 2 ** INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      REFILL_REQ,
      REFILL_WAIT
   } cache_state_t;

   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [1:0] get_word(input logic [ADDR_W-1:0] addr);
      return addr[3:2];
   endfunction
endpackage

// File: rtl/cache_tag_store.sv
// Tag array with valid/dirty bits; combinational read, synchronous write.
module cache_tag_store
   import dm_cache_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX_W-1:0] rd_index,
   output logic [TAG_W-1:0]   rd_tag,
   output logic               rd_valid,
   output logic               rd_dirty,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic               wr_dirty
);
   logic [TAG_W-1:0] tag_mem [LINES];
   logic [LINES-1:0] valid_q, valid_d;
   logic [LINES-1:0] dirty_q, dirty_d;

   // Tags need no reset: an entry is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) tag_mem[wr_index] <= wr_tag;
   end

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (wr_en) begin
         valid_d[wr_index] = 1'b1;
         dirty_d[wr_index] = wr_dirty;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   assign rd_tag   = tag_mem[rd_index];
   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache controller.
// state       | meaning
// IDLE        | ready for a CPU request
// LOOKUP      | tag compare; hit completes, miss picks writeback or refill
// WRITEBACK   | dirty victim line offered to memory
// REFILL_REQ  | line read request offered to memory
// REFILL_WAIT | waiting for refill data, then re-run LOOKUP
module cache_controller
   import dm_cache_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               cpu_req_valid,
   output logic               cpu_req_ready,
   input  logic               cpu_req_we,
   input  logic [ADDR_W-1:0]  cpu_req_addr,
   input  logic [WORD_W-1:0]  cpu_req_wdata,
   output logic               cpu_resp_valid,
   output logic [WORD_W-1:0]  cpu_resp_rdata,
   output logic [INDEX_W-1:0] ds_index,
   output logic [LINE_W-1:0]  ds_writedata,
   output logic               ds_writeenable,
   input  logic [LINE_W-1:0]  ds_readdata,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic               mem_req_we,
   output logic [ADDR_W-1:0]  mem_req_addr,
   output logic [LINE_W-1:0]  mem_req_wdata,
   input  logic               mem_resp_valid,
   input  logic [LINE_W-1:0]  mem_resp_rdata
);
   cache_state_t        state_q, state_d;
   logic                req_we_q, req_we_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic [WORD_W-1:0]   resp_rdata_q, resp_rdata_d;

   logic [TAG_W-1:0]    rd_tag;
   logic                rd_valid, rd_dirty;
   logic                tag_wr_en, tag_wr_dirty;
   logic                hit;
   logic [LINE_W-1:0]   merged_line;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [1:0]          req_word;

   assign req_tag   = get_tag(req_addr_q);
   assign req_index = get_index(req_addr_q);
   assign req_word  = get_word(req_addr_q);
   assign hit       = rd_valid && (rd_tag == req_tag);

   cache_tag_store u_tag_store (
      .clk      (clk),
      .reset    (reset),
      .rd_index (req_index),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .wr_en    (tag_wr_en),
      .wr_index (req_index),
      .wr_tag   (req_tag),
      .wr_dirty (tag_wr_dirty)
   );

   always_comb begin
      merged_line = ds_readdata;
      merged_line[req_word*WORD_W +: WORD_W] = req_wdata_q;
   end

   always_comb begin
      state_d        = state_q;
      req_we_d       = req_we_q;
      req_addr_d     = req_addr_q;
      req_wdata_d    = req_wdata_q;
      resp_valid_d   = 1'b0;
      resp_rdata_d   = resp_rdata_q;
      cpu_req_ready  = 1'b0;
      ds_index       = req_index;
      ds_writedata   = '0;
      ds_writeenable = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      tag_wr_en      = 1'b0;
      tag_wr_dirty   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cpu_req_ready = 1'b1;
            if (cpu_req_valid) begin
               req_we_d    = cpu_req_we;
               req_addr_d  = cpu_req_addr;
               req_wdata_d = cpu_req_wdata;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               resp_valid_d = 1'b1;
               state_d      = IDLE;
               if (req_we_q) begin
                  ds_writedata   = merged_line;
                  ds_writeenable = 1'b1;
                  tag_wr_en      = 1'b1;
                  tag_wr_dirty   = 1'b1;
               end else begin
                  resp_rdata_d = ds_readdata[req_word*WORD_W +: WORD_W];
               end
            end else if (rd_valid && rd_dirty) begin
               state_d = WRITEBACK;
            end else begin
               state_d = REFILL_REQ;
            end
         end
         WRITEBACK: begin
            // ds_index stays on the request index, so the victim line is stable while stalled.
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {rd_tag, req_index, {OFFSET_W{1'b0}}};
            mem_req_wdata = ds_readdata;
            if (mem_req_ready) state_d = REFILL_REQ;
         end
         REFILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_tag, req_index, {OFFSET_W{1'b0}}};
            if (mem_req_ready) state_d = REFILL_WAIT;
         end
         REFILL_WAIT: begin
            if (mem_resp_valid) begin
               ds_writedata   = mem_resp_rdata;
               ds_writeenable = 1'b1;
               tag_wr_en      = 1'b1;
               state_d        = LOOKUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         req_we_q     <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         req_we_q     <= req_we_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign cpu_resp_valid = resp_valid_q;
   assign cpu_resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural data store and scripted memory.
module tb_cache_controller;
   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
   logic [31:0]   cpu_req_addr, cpu_req_wdata;
   logic          cpu_resp_valid;
   logic [31:0]   cpu_resp_rdata;
   logic [9:0]    ds_index;
   logic [127:0]  ds_writedata, ds_readdata;
   logic          ds_writeenable;
   logic          mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0]   mem_req_addr;
   logic [127:0]  mem_req_wdata;
   logic          mem_resp_valid;
   logic [127:0]  mem_resp_rdata;

   int checks = 0;
   int errors = 0;

   logic [127:0] ds_mem [1024];
   int           ds_wr_total = 0;
   int           ds_wr_idx1 = 0;
   int           mem_req_cycles = 0;
   bit           mem_we_seen = 1'b0;

   localparam logic [127:0] L1  = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
   localparam logic [127:0] L1M = 128'h0000_4444_DEAD_BEEF_0000_2222_0000_1111;
   localparam logic [127:0] L3  = 128'h0303_0303_0202_0202_0101_0101_ABCD_0001;
   localparam logic [127:0] L4  = 128'h4040_0003_3030_0002_2020_0001_1010_0000;
   localparam logic [127:0] L5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
   localparam logic [127:0] L6  = 128'hCCCC_0004_CCCC_0003_CCCC_0002_CCCC_0001;

   cache_controller dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_we     (cpu_req_we),
      .cpu_req_addr   (cpu_req_addr),
      .cpu_req_wdata  (cpu_req_wdata),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_resp_rdata (cpu_resp_rdata),
      .ds_index       (ds_index),
      .ds_writedata   (ds_writedata),
      .ds_writeenable (ds_writeenable),
      .ds_readdata    (ds_readdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   always #5 clk = ~clk;

   assign ds_readdata = ds_mem[ds_index];

   always @(posedge clk) begin
      if (ds_writeenable) begin
         ds_mem[ds_index] <= ds_writedata;
         ds_wr_total++;
         if (ds_index == 10'd1) ds_wr_idx1++;
      end
      if (mem_req_valid) begin
         mem_req_cycles++;
         if (mem_req_we) mem_we_seen = 1'b1;
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_req_addr  = addr;
      cpu_req_wdata = wdata;
      @(negedge clk);
      cpu_req_valid = 1'b0;
   endtask

   task automatic wait_mem_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_resp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cpu_resp_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Accept the pending read request and return one refill line.
   task automatic serve_refill(input logic [127:0] line);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = line;
      @(negedge clk);
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || cpu_resp_rdata !== 32'h0 ||
          mem_req_valid !== 1'b0 || ds_writeenable !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b resp_valid=%b rdata=%h mem_valid=%b ds_we=%b required 1 0 0 0 0",
                  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_req_valid, ds_writeenable);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cold_load();
      bit ok;
      issue(1'b0, 32'h0000_0010, 32'h0);
      checks++;
      if (cpu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL cold_ready_in_lookup: got %b required 0", cpu_req_ready);
      end
      wait_mem_req(ok);
      checks++;
      if (!ok || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0000_0010) begin
         errors++;
         $display("FAIL cold_refill_req: valid=%b we=%b addr=%h required 1 0 00000010",
                  mem_req_valid, mem_req_we, mem_req_addr);
      end
      serve_refill(L1);
      @(negedge clk);
      checks++;
      if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h0000_1111) begin
         errors++;
         $display("FAIL cold_load_resp: valid=%b rdata=%h required 1 00001111", cpu_resp_valid, cpu_resp_rdata);
      end
      checks++;
      if (ds_wr_idx1 !== 1) begin
         errors++;
         $display("FAIL cold_ds_writes_idx1: got %0d required 1", ds_wr_idx1);
      end
      @(negedge clk);
   endtask

   task automatic test_store_hit();
      int mem_before;
      mem_before = mem_req_cycles;
      issue(1'b1, 32'h0000_0018, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (cpu_resp_valid !== 1'b1 || cpu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL store_hit_resp: valid=%b ready=%b required 1 1", cpu_resp_valid, cpu_req_ready);
      end
      issue(1'b0, 32'h0000_0018, 32'h0);
      checks++;
      if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_hit_lookup: valid=%b ready=%b required 0 0", cpu_resp_valid, cpu_req_ready);
      end
      @(negedge clk);
      checks++;
      if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL load_hit_resp: valid=%b rdata=%h required 1 deadbeef", cpu_resp_valid, cpu_resp_rdata);
      end
      checks++;
      if (mem_req_cycles !== mem_before || ds_mem[1] !== L1M) begin
         errors++;
         $display("FAIL store_hit_side_effects: mem_cycles=%0d (was %0d) line=%h required line %h",
                  mem_req_cycles, mem_before, ds_mem[1], L1M);
      end
      @(negedge clk);
   endtask

   task automatic test_dirty_evict();
      bit ok;
      bit stable;
      logic [31:0]  a0;
      logic [127:0] w0;
      issue(1'b0, 32'h0000_4010, 32'h0);
      wait_mem_req(ok);
      checks++;
      if (!ok || mem_req_we !== 1'b1 || mem_req_addr !== 32'h0000_0010 || mem_req_wdata !== L1M) begin
         errors++;
         $display("FAIL writeback_req: valid=%b we=%b addr=%h wdata=%h required 1 1 00000010 %h",
                  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, L1M);
      end
      a0 = mem_req_addr;
      w0 = mem_req_wdata;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== a0 || mem_req_wdata !== w0)
            stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL writeback_stall_stable: valid=%b we=%b addr=%h required held 1 1 %h",
                  mem_req_valid, mem_req_we, mem_req_addr, a0);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0000_4010) begin
         errors++;
         $display("FAIL evict_refill_req: valid=%b we=%b addr=%h required 1 0 00004010",
                  mem_req_valid, mem_req_we, mem_req_addr);
      end
      serve_refill(L3);
      wait_resp(ok);
      checks++;
      if (!ok || cpu_resp_rdata !== 32'hABCD_0001) begin
         errors++;
         $display("FAIL evict_load_resp: seen=%b rdata=%h required 1 abcd0001", ok, cpu_resp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit ok;
      issue(1'b0, 32'h0000_3FF0, 32'h0);
      wait_mem_req(ok);
      serve_refill(L4);
      wait_resp(ok);
      checks++;
      if (!ok || cpu_resp_rdata !== 32'h1010_0000) begin
         errors++;
         $display("FAIL b2b_setup_resp: seen=%b rdata=%h required 1 10100000", ok, cpu_resp_rdata);
      end
      @(negedge clk);
      cpu_req_valid = 1'b1;
      cpu_req_we    = 1'b0;
      cpu_req_addr  = 32'h0000_3FF0;
      @(negedge clk);
      cpu_req_addr  = 32'h0000_3FFC;
      checks++;
      if (cpu_req_ready !== 1'b0 || cpu_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first_lookup: ready=%b resp=%b required 0 0", cpu_req_ready, cpu_resp_valid);
      end
      @(negedge clk);
      checks++;
      if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h1010_0000) begin
         errors++;
         $display("FAIL b2b_first_resp: ready=%b resp=%b rdata=%h required 1 1 10100000",
                  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata);
      end
      @(negedge clk);
      cpu_req_valid = 1'b0;
      checks++;
      if (cpu_req_ready !== 1'b0 || cpu_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_lookup: ready=%b resp=%b required 0 0", cpu_req_ready, cpu_resp_valid);
      end
      @(negedge clk);
      checks++;
      if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h4040_0003) begin
         errors++;
         $display("FAIL b2b_second_resp: ready=%b resp=%b rdata=%h required 1 1 40400003",
                  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_refill();
      bit ok;
      int wr_before;
      issue(1'b0, 32'h0002_0030, 32'h0);
      wait_mem_req(ok);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || cpu_resp_rdata !== 32'h0 ||
          mem_req_valid !== 1'b0 || ds_writeenable !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_refill: ready=%b resp=%b rdata=%h mem_valid=%b ds_we=%b required 1 0 0 0 0",
                  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_req_valid, ds_writeenable);
      end
      @(negedge clk);
      reset = 1'b0;
      wr_before = ds_wr_total;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = L5;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++;
      if (ds_wr_total !== wr_before || cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL stale_resp_ignored: ds_writes=%0d (was %0d) ready=%b resp=%b required unchanged 1 0",
                  ds_wr_total, wr_before, cpu_req_ready, cpu_resp_valid);
      end
      issue(1'b0, 32'h0002_0030, 32'h0);
      wait_mem_req(ok);
      checks++;
      if (!ok || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0002_0030) begin
         errors++;
         $display("FAIL post_reset_miss: seen=%b we=%b addr=%h required 1 0 00020030", ok, mem_req_we, mem_req_addr);
      end
      serve_refill(L5);
      wait_resp(ok);
      @(negedge clk);
   endtask

   task automatic test_store_miss();
      bit ok;
      mem_we_seen = 1'b0;
      issue(1'b1, 32'h0001_0020, 32'h1234_5678);
      wait_mem_req(ok);
      checks++;
      if (!ok || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0001_0020) begin
         errors++;
         $display("FAIL store_miss_refill_req: seen=%b we=%b addr=%h required 1 0 00010020", ok, mem_req_we, mem_req_addr);
      end
      serve_refill(L6);
      wait_resp(ok);
      checks++;
      if (!ok || ds_mem[2] !== {L6[127:32], 32'h1234_5678}) begin
         errors++;
         $display("FAIL store_miss_merge: seen=%b line=%h required %h", ok, ds_mem[2], {L6[127:32], 32'h1234_5678});
      end
      @(negedge clk);
      issue(1'b0, 32'h0001_0020, 32'h0);
      @(negedge clk);
      checks++;
      if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h1234_5678 || mem_we_seen !== 1'b0) begin
         errors++;
         $display("FAIL store_miss_readback: resp=%b rdata=%h mem_we_seen=%b required 1 12345678 0",
                  cpu_resp_valid, cpu_resp_rdata, mem_we_seen);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ds_mem[i] = '0;
      reset          = 1'b1;
      cpu_req_valid  = 1'b0;
      cpu_req_we     = 1'b0;
      cpu_req_addr   = '0;
      cpu_req_wdata  = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      @(negedge clk);
      test_reset();
      test_cold_load();
      test_store_hit();
      test_dirty_evict();
      test_back_to_back();
      test_reset_mid_refill();
      test_store_miss();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller; initiator side of the 1024-line x 128-bit cache data store.
- Accepts CPU word requests and drives the data store index/writedata/writeenable.
- Keeps tag/valid/dirty state and runs line writeback and refill over a valid/ready memory interface.
- Sits between the CPU load/store unit and the main-memory port.

Parameters:
INDEX_W, 10, line index bits (1024 lines)
TAG_W, 18, tag bits; ADDR = TAG_W+INDEX_W+4 = 32
LINE_W, 128, line width (4 words)
WORD_W, 32, CPU word width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  controller can accept request
cpu_req_we  in  1  1=store, 0=load
cpu_req_addr  in  32  byte address; [31:14] tag, [13:4] index, [3:2] word, [1:0] ignored
cpu_req_wdata  in  32  store data
cpu_resp_valid  out  1  one-cycle completion pulse (loads and stores)
cpu_resp_rdata  out  32  load data, valid with cpu_resp_valid
ds_index  out  INDEX_W  data store line index
ds_writedata  out  LINE_W  data store write line
ds_writeenable  out  1  data store write strobe
ds_readdata  in  LINE_W  data store combinational read of ds_index
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=writeback, 0=refill read
mem_req_addr  out  32  line address, bits [3:0]=0
mem_req_wdata  out  LINE_W  writeback line
mem_resp_valid  in  1  refill data valid (exactly one per read request)
mem_resp_rdata  in  LINE_W  refill line

Behaviour:
- Reset (async, active-high): state=IDLE. All valid and dirty bits clear. cpu_resp_valid=0, cpu_resp_rdata=0, mem_req_valid=0, ds_writeenable=0.
- Reset mid-operation abandons any outstanding memory transaction; dirty data is lost; memory must tolerate a dropped request.
- States: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT.
- IDLE: cpu_req_ready=1, high only in IDLE. On valid&&ready, latch we/addr/wdata and go to LOOKUP.
- LOOKUP: ds_index=latched index; compare tag store entry.
  - Hit load: register the selected word (word offset 0 = bits [31:0]) into cpu_resp_rdata; pulse cpu_resp_valid next cycle; go to IDLE.
  - Hit store: ds_writedata=ds_readdata with the selected word replaced; ds_writeenable=1 this cycle; set dirty; pulse cpu_resp_valid next cycle; go to IDLE.
  - Miss, dirty victim: go to WRITEBACK. Miss, clean or invalid: go to REFILL_REQ.
- Hit latency: request accepted at cycle N edge, LOOKUP in N+1, cpu_resp_valid high in N+2 together with cpu_req_ready. Throughput is one request per 2 cycles.
- WRITEBACK:
  - mem_req_valid=1, we=1, addr={victim tag,index,4'b0}, wdata=ds_readdata.
  - All outputs held stable until mem_req_ready.
  - On ready, go to REFILL_REQ.
  - No response is expected for a write.
- REFILL_REQ: mem_req_valid=1, we=0, addr={req tag,index,4'b0}. On ready, go to REFILL_WAIT.
- REFILL_WAIT:
  - On mem_resp_valid: ds_writedata=mem_resp_rdata, ds_writeenable=1; tag=req tag, valid=1, dirty=0; go to LOOKUP.
  - LOOKUP then hits and completes the request normally, including store merge.
- mem_req_valid must not drop before ready, except under reset.
- mem_resp_valid outside REFILL_WAIT is ignored.
- Simultaneous mem_req_ready and mem_resp_valid in REFILL_REQ: only ready is used; the memory never responds in the acceptance cycle.
- ds_writeenable is never asserted outside the LOOKUP store hit and REFILL_WAIT response cycles.
- cpu_resp_rdata holds its last value between pulses. It is undefined-but-stable for stores; implement it as hold.
- Index and tag arithmetic are pure bit slices; no wrap-around arithmetic.

Decomposition:
- Package dm_cache_pkg: state enum cache_state_t, width constants (INDEX_W, TAG_W, LINE_W, WORD_W, OFFSET_W=4), and address field slice functions get_tag/get_index/get_word.
- Sub-module cache_tag_store:
  - 1024-entry tag array plus valid/dirty flop vectors.
  - Valid/dirty are cleared by async reset.
  - Combinational read by index; synchronous write of tag/valid/dirty.

Test Plan:
- Cold load 0x0000_0010 -> miss; REFILL_REQ addr 0x0000_0010 we=0; mem returns line 0x4444_3333_2222_1111 pattern -> cpu_resp_rdata=0x1111 word, data store index 1 written once.
- Store 0xDEAD_BEEF to 0x0000_0018 then load 0x0000_0018 -> both hit, no mem_req_valid; load returns 0xDEAD_BEEF 2 cycles after acceptance; dirty[1]=1.
- Load 0x0000_4010 (same index 1, tag 1) with dirty line -> WRITEBACK addr 0x0000_0010 we=1 with modified line, then REFILL_REQ addr 0x0000_4010; hold mem_req_ready low 5 cycles -> request outputs stable.
- Two back-to-back hits to index 1023 (addr 0x0000_3FF0, 0x0000_3FFC) -> cpu_req_ready low exactly in LOOKUP cycles; responses at N+2, N+4.
- Assert reset during REFILL_WAIT -> outputs at reset values immediately; stale mem_resp_valid after reset is ignored; next load to same address misses.
- Store miss to clean line 0x0001_0020 -> refill, then LOOKUP merges word 0 of 0x1234_5678; mem_req_we never 1.
